// File: rtl/bp_common_pkg.sv
// Shared definitions for the streaming vector dot-product accelerator:
// CSR byte offsets, operation encoding and status bit positions.
package bp_common_pkg;

    localparam logic [7:0] CSR_A_PTR_OFF   = 8'h00;
    localparam logic [7:0] CSR_B_PTR_OFF   = 8'h08;
    localparam logic [7:0] CSR_LEN_OFF     = 8'h10;
    localparam logic [7:0] CSR_OP_OFF      = 8'h18;
    localparam logic [7:0] CSR_RES_PTR_OFF = 8'h20;
    localparam logic [7:0] CSR_START_OFF   = 8'h28;
    localparam logic [7:0] CSR_STATUS_OFF  = 8'h30;
    localparam logic [7:0] CSR_RESULT_OFF  = 8'h38;

    typedef enum logic [1:0] {
        OP_DOT = 2'd0,
        OP_SUM = 2'd1
    } bp_cacc_op_e;

    localparam int unsigned STATUS_BUSY_BIT  = 0;
    localparam int unsigned STATUS_DONE_BIT  = 1;
    localparam int unsigned STATUS_ERROR_BIT = 2;

endpackage

// File: rtl/bp_cacc_mac.sv
// Registered multiply-accumulate; product and sum wrap at data_width_p bits.
module bp_cacc_mac #(
    parameter int unsigned data_width_p = 64
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    clear_i,
    input  logic                    en_i,
    input  logic [data_width_p-1:0] a_i,
    input  logic [data_width_p-1:0] b_i,
    output logic [data_width_p-1:0] acc_o
);

    logic [data_width_p-1:0] acc_q, acc_d, prod;

    // Next accumulator value: clear has priority over accumulate
    always_comb begin
        prod  = a_i * b_i;
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + prod;
        end
    end

    // Accumulator register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/bp_cacc_vdp_stream.sv
// CSR-programmed streaming engine: fetches vector elements one request at a
// time, accumulates a dot product or reduction, and stores the result.
module bp_cacc_vdp_stream
    import bp_common_pkg::*;
#(
    parameter int unsigned data_width_p  = 64,
    parameter int unsigned paddr_width_p = 40,
    parameter int unsigned len_width_p   = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,

    input  logic                     csr_v_i,
    input  logic                     csr_w_i,
    input  logic [7:0]               csr_addr_i,
    input  logic [data_width_p-1:0]  csr_data_i,
    output logic                     csr_ready_o,

    output logic                     csr_resp_v_o,
    output logic [data_width_p-1:0]  csr_resp_data_o,
    input  logic                     csr_resp_yumi_i,

    output logic                     mem_req_v_o,
    output logic                     mem_req_w_o,
    output logic [paddr_width_p-1:0] mem_req_addr_o,
    output logic [data_width_p-1:0]  mem_req_data_o,
    input  logic                     mem_req_ready_i,

    input  logic                     mem_resp_v_i,
    input  logic [data_width_p-1:0]  mem_resp_data_i
);

    localparam int unsigned bytes_lp    = data_width_p / 8;
    localparam int unsigned lg_bytes_lp = $clog2(bytes_lp);
    localparam logic [data_width_p-1:0] align_mask_lp = data_width_p'(bytes_lp - 1);
    localparam logic [data_width_p-1:0] op_dot_lp     = data_width_p'(OP_DOT);
    localparam logic [data_width_p-1:0] op_sum_lp     = data_width_p'(OP_SUM);

    typedef enum logic [3:0] {
        S_IDLE, S_LD_A, S_WT_A, S_LD_B, S_WT_B, S_ACC, S_ST, S_WT_ST, S_FIN
    } state_e;

    state_e                   state_q, state_d;
    logic [data_width_p-1:0]  a_ptr_q, a_ptr_d, b_ptr_q, b_ptr_d;
    logic [data_width_p-1:0]  op_q, op_d, res_ptr_q, res_ptr_d, result_q, result_d;
    logic [len_width_p-1:0]   len_q, len_d, idx_q, idx_d;
    logic [data_width_p-1:0]  opa_q, opa_d, opb_q, opb_d;
    logic                     done_q, done_d, error_q, error_d;
    logic                     resp_v_q, resp_v_d;
    logic [data_width_p-1:0]  resp_data_q, resp_data_d;

    logic                     busy, csr_accept, csr_wr, op_is_dot, op_is_sum, cfg_bad;
    logic [data_width_p-1:0]  rd_data, acc, mac_b;
    logic                     mac_clear, mac_en;
    logic [len_width_p:0]     idx_inc;
    logic [paddr_width_p-1:0] elem_off;

    assign busy        = (state_q != S_IDLE);
    assign csr_accept  = csr_v_i & ~resp_v_q;
    assign csr_wr      = csr_accept & csr_w_i;
    assign op_is_dot   = (op_q == op_dot_lp);
    assign op_is_sum   = (op_q == op_sum_lp);
    assign idx_inc     = {1'b0, idx_q} + (len_width_p + 1)'(1);
    assign elem_off    = paddr_width_p'(idx_q) << lg_bytes_lp;

    // B pointer alignment only matters when B is actually fetched
    assign cfg_bad = ~(op_is_dot | op_is_sum)
                   | ((a_ptr_q & align_mask_lp) != '0)
                   | ((res_ptr_q & align_mask_lp) != '0)
                   | (op_is_dot & ((b_ptr_q & align_mask_lp) != '0));

    assign csr_ready_o     = ~resp_v_q;
    assign csr_resp_v_o    = resp_v_q;
    assign csr_resp_data_o = resp_data_q;

    // CSR read mux, built from pre-transition register state
    always_comb begin
        rd_data = '0;
        case (csr_addr_i)
            CSR_A_PTR_OFF:   rd_data = a_ptr_q;
            CSR_B_PTR_OFF:   rd_data = b_ptr_q;
            CSR_LEN_OFF:     rd_data = data_width_p'(len_q);
            CSR_OP_OFF:      rd_data = op_q;
            CSR_RES_PTR_OFF: rd_data = res_ptr_q;
            CSR_STATUS_OFF: begin
                rd_data[STATUS_BUSY_BIT]  = busy;
                rd_data[STATUS_DONE_BIT]  = done_q;
                rd_data[STATUS_ERROR_BIT] = error_q;
            end
            CSR_RESULT_OFF:  rd_data = result_q;
            default:         rd_data = '0;
        endcase
    end

    // CSR command handling, FSM next state and memory request outputs
    always_comb begin
        state_d        = state_q;
        a_ptr_d        = a_ptr_q;
        b_ptr_d        = b_ptr_q;
        len_d          = len_q;
        op_d           = op_q;
        res_ptr_d      = res_ptr_q;
        result_d       = result_q;
        idx_d          = idx_q;
        opa_d          = opa_q;
        opb_d          = opb_q;
        done_d         = done_q;
        error_d        = error_q;
        resp_v_d       = resp_v_q;
        resp_data_d    = resp_data_q;
        mac_clear      = 1'b0;
        mac_en         = 1'b0;
        mac_b          = opb_q;
        mem_req_v_o    = 1'b0;
        mem_req_w_o    = 1'b0;
        mem_req_addr_o = '0;
        mem_req_data_o = '0;

        if (resp_v_q && csr_resp_yumi_i) begin
            resp_v_d = 1'b0;
        end
        if (csr_accept) begin
            resp_v_d    = 1'b1;
            resp_data_d = csr_w_i ? '0 : rd_data;
        end

        if (csr_wr && !busy) begin
            case (csr_addr_i)
                CSR_A_PTR_OFF:   a_ptr_d   = csr_data_i;
                CSR_B_PTR_OFF:   b_ptr_d   = csr_data_i;
                CSR_LEN_OFF:     len_d     = csr_data_i[len_width_p-1:0];
                CSR_OP_OFF:      op_d      = csr_data_i;
                CSR_RES_PTR_OFF: res_ptr_d = csr_data_i;
                default: ;
            endcase
        end
        if (csr_wr && csr_addr_i == CSR_STATUS_OFF) begin
            done_d  = 1'b0;
            error_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (csr_wr && csr_addr_i == CSR_START_OFF && csr_data_i[0]) begin
                    done_d    = 1'b0;
                    error_d   = 1'b0;
                    mac_clear = 1'b1;
                    idx_d     = '0;
                    // Bad configuration finishes immediately without going busy
                    if (cfg_bad) begin
                        done_d  = 1'b1;
                        error_d = 1'b1;
                    end else if (len_q == '0) begin
                        state_d = S_ST;
                    end else begin
                        state_d = S_LD_A;
                    end
                end
            end
            S_LD_A: begin
                mem_req_v_o    = 1'b1;
                mem_req_addr_o = paddr_width_p'(a_ptr_q) + elem_off;
                if (mem_req_ready_i) state_d = S_WT_A;
            end
            S_WT_A: begin
                if (mem_resp_v_i) begin
                    opa_d   = mem_resp_data_i;
                    state_d = op_is_dot ? S_LD_B : S_ACC;
                end
            end
            S_LD_B: begin
                mem_req_v_o    = 1'b1;
                mem_req_addr_o = paddr_width_p'(b_ptr_q) + elem_off;
                if (mem_req_ready_i) state_d = S_WT_B;
            end
            S_WT_B: begin
                if (mem_resp_v_i) begin
                    opb_d   = mem_resp_data_i;
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                mac_en = 1'b1;
                mac_b  = op_is_dot ? opb_q : data_width_p'(1);
                if (idx_inc < {1'b0, len_q}) begin
                    idx_d   = idx_inc[len_width_p-1:0];
                    state_d = S_LD_A;
                end else begin
                    state_d = S_ST;
                end
            end
            S_ST: begin
                mem_req_v_o    = 1'b1;
                mem_req_w_o    = 1'b1;
                mem_req_addr_o = paddr_width_p'(res_ptr_q);
                mem_req_data_o = acc;
                if (mem_req_ready_i) state_d = S_WT_ST;
            end
            S_WT_ST: begin
                if (mem_resp_v_i) state_d = S_FIN;
            end
            S_FIN: begin
                result_d = acc;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and CSR registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            a_ptr_q     <= '0;
            b_ptr_q     <= '0;
            len_q       <= '0;
            op_q        <= '0;
            res_ptr_q   <= '0;
            result_q    <= '0;
            idx_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            resp_v_q    <= 1'b0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            a_ptr_q     <= a_ptr_d;
            b_ptr_q     <= b_ptr_d;
            len_q       <= len_d;
            op_q        <= op_d;
            res_ptr_q   <= res_ptr_d;
            result_q    <= result_d;
            idx_q       <= idx_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            done_q      <= done_d;
            error_q     <= error_d;
            resp_v_q    <= resp_v_d;
            resp_data_q <= resp_data_d;
        end
    end

    bp_cacc_mac #(.data_width_p(data_width_p)) u_mac (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (mac_clear),
        .en_i    (mac_en),
        .a_i     (opa_q),
        .b_i     (mac_b),
        .acc_o   (acc)
    );

endmodule

// File: tb/tb_bp_cacc_vdp_stream.sv
// Scoreboard bench for bp_cacc_vdp_stream with a behavioural memory and
// an arithmetic reference model of each vector operation.
module tb_bp_cacc_vdp_stream;

    localparam int DW = 64;
    localparam int PW = 40;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          csr_v_i, csr_w_i;
    logic [7:0]    csr_addr_i;
    logic [DW-1:0] csr_data_i;
    logic          csr_ready_o, csr_resp_v_o;
    logic [DW-1:0] csr_resp_data_o;
    logic          csr_resp_yumi_i;
    logic          mem_req_v_o, mem_req_w_o, mem_req_ready_i;
    logic [PW-1:0] mem_req_addr_o;
    logic [DW-1:0] mem_req_data_o;
    logic          mem_resp_v_i;
    logic [DW-1:0] mem_resp_data_i;

    bp_cacc_vdp_stream #(.data_width_p(DW), .paddr_width_p(PW), .len_width_p(LW)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .csr_v_i(csr_v_i), .csr_w_i(csr_w_i), .csr_addr_i(csr_addr_i), .csr_data_i(csr_data_i),
        .csr_ready_o(csr_ready_o), .csr_resp_v_o(csr_resp_v_o), .csr_resp_data_o(csr_resp_data_o),
        .csr_resp_yumi_i(csr_resp_yumi_i),
        .mem_req_v_o(mem_req_v_o), .mem_req_w_o(mem_req_w_o), .mem_req_addr_o(mem_req_addr_o),
        .mem_req_data_o(mem_req_data_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_resp_v_i(mem_resp_v_i), .mem_resp_data_i(mem_resp_data_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [logic [PW-1:0]];
    logic [DW-1:0] csr_exp_q [$];
    string         csr_name_q [$];
    logic [PW-1:0] exp_rd_q [$];
    logic [PW-1:0] exp_st_addr_q [$];
    logic [DW-1:0] exp_st_data_q [$];

    int st_acks = 0;
    int rd_hs = 0;
    int stall_n = 0;
    int dly_lo = 0;
    int dly_hi = 2;
    int yumi_fixed = -1;

    logic [2:0]    model_status;
    logic [DW-1:0] model_result;
    logic [DW-1:0] av [8];
    logic [DW-1:0] bv [8];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got event, expected none or timeout-free completion", name);
    endtask

    function automatic logic [DW-1:0] mem_rd(input logic [PW-1:0] a);
        return mem.exists(a) ? mem[a] : '0;
    endfunction

    // Memory responder: random ready, optional forced stalls, delayed responses
    initial begin
        bit            pending = 0, pend_w = 0, stalled = 0;
        int            pend_cnt = 0, stall_left = 0;
        logic [PW-1:0] pend_addr = '0, s_addr = '0;
        logic [DW-1:0] s_data = '0;
        logic          s_w = 1'b0;
        mem_req_ready_i = 1'b0;
        mem_resp_v_i    = 1'b0;
        mem_resp_data_i = '0;
        forever begin
            @(negedge clk);
            mem_resp_v_i = 1'b0;
            if (pending) begin
                if (pend_cnt == 0) begin
                    mem_resp_v_i    = 1'b1;
                    mem_resp_data_i = pend_w ? 64'h0000_0000_0000_0ACC : mem_rd(pend_addr);
                    if (pend_w) st_acks++;
                    pending = 0;
                end else begin
                    pend_cnt--;
                end
            end
            if (stalled) begin
                chk("req_held", {63'd0, mem_req_v_o}, 64'd1);
                chk("req_addr_stable", {24'd0, mem_req_addr_o}, {24'd0, s_addr});
                chk("req_data_stable", mem_req_data_o, s_data);
                chk("req_w_stable", {63'd0, mem_req_w_o}, {63'd0, s_w});
            end
            if (mem_req_v_o === 1'b1) begin
                chk("one_outstanding", {63'd0, pending}, 64'd0);
                if (!stalled) stall_left = stall_n;
                if (stall_left > 0 || $urandom_range(0, 3) == 0) begin
                    if (stall_left > 0) stall_left--;
                    mem_req_ready_i = 1'b0;
                    stalled = 1;
                    s_addr  = mem_req_addr_o;
                    s_data  = mem_req_data_o;
                    s_w     = mem_req_w_o;
                end else begin
                    mem_req_ready_i = 1'b1;
                    stalled = 0;
                    if (mem_req_w_o) begin
                        if (exp_st_addr_q.size() == 0) begin
                            fail_now("unexpected_store");
                        end else begin
                            chk("store_addr", {24'd0, mem_req_addr_o}, {24'd0, exp_st_addr_q.pop_front()});
                            chk("store_data", mem_req_data_o, exp_st_data_q.pop_front());
                        end
                        mem[mem_req_addr_o] = mem_req_data_o;
                    end else begin
                        rd_hs++;
                        if (exp_rd_q.size() == 0) begin
                            fail_now("unexpected_read");
                        end else begin
                            chk("read_addr", {24'd0, mem_req_addr_o}, {24'd0, exp_rd_q.pop_front()});
                        end
                    end
                    pending   = 1;
                    pend_w    = mem_req_w_o;
                    pend_addr = mem_req_addr_o;
                    pend_cnt  = $urandom_range(dly_hi, dly_lo);
                end
            end else begin
                mem_req_ready_i = 1'($urandom_range(0, 1));
                stalled = 0;
            end
        end
    end

    // CSR response monitor: consumes responses after a delay and scores them
    initial begin
        int            wcnt = 0, target = 0;
        logic [DW-1:0] held = '0;
        string         nm;
        csr_resp_yumi_i = 1'b0;
        forever begin
            @(negedge clk);
            if (csr_resp_yumi_i) begin
                csr_resp_yumi_i = 1'b0;
                wcnt = 0;
            end else if (csr_resp_v_o === 1'b1) begin
                if (wcnt == 0) begin
                    held   = csr_resp_data_o;
                    target = (yumi_fixed >= 0) ? yumi_fixed : int'($urandom_range(0, 2));
                end else begin
                    chk("csr_resp_stable", csr_resp_data_o, held);
                end
                if (wcnt >= target) begin
                    csr_resp_yumi_i = 1'b1;
                    if (csr_exp_q.size() == 0) begin
                        fail_now("unexpected_csr_resp");
                    end else begin
                        nm = csr_name_q.pop_front();
                        chk(nm, csr_resp_data_o, csr_exp_q.pop_front());
                    end
                end else begin
                    wcnt++;
                end
            end
        end
    end

    task automatic csr(input bit w, input logic [7:0] addr, input logic [DW-1:0] data,
                       input logic [DW-1:0] exp, input string name);
        int n = 0;
        @(negedge clk);
        while (csr_ready_o !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (csr_ready_o !== 1'b1) begin
            fail_now("csr_ready_timeout");
            return;
        end
        csr_v_i    = 1'b1;
        csr_w_i    = w;
        csr_addr_i = addr;
        csr_data_i = data;
        csr_exp_q.push_back(exp);
        csr_name_q.push_back(name);
        @(negedge clk);
        csr_v_i = 1'b0;
        chk("csr_resp_next_cycle", {63'd0, csr_resp_v_o}, 64'd1);
        chk("csr_ready_low_while_resp", {63'd0, csr_ready_o}, 64'd0);
    endtask

    task automatic drain();
        int n = 0;
        while ((csr_exp_q.size() != 0 || csr_resp_v_o === 1'b1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail_now("csr_drain_timeout");
    endtask

    // Program an operation, compute its expected traffic and result, start it
    task automatic setup_and_start(input logic [DW-1:0] a_ptr, input logic [DW-1:0] b_ptr,
                                   input int len, input logic [DW-1:0] op,
                                   input logic [DW-1:0] res_ptr,
                                   output bit bad, output logic [DW-1:0] sum, output int base);
        logic [PW-1:0] aa, ba;
        for (int i = 0; i < len; i++) begin
            aa = PW'(a_ptr + 64'(i) * 8);
            ba = PW'(b_ptr + 64'(i) * 8);
            mem[aa] = av[i];
            if (op == 0) mem[ba] = bv[i];
        end
        csr(1, 8'h00, a_ptr, '0, "wr_a_ptr");
        csr(1, 8'h08, b_ptr, '0, "wr_b_ptr");
        csr(1, 8'h10, 64'(len), '0, "wr_len");
        csr(1, 8'h18, op, '0, "wr_op");
        csr(1, 8'h20, res_ptr, '0, "wr_res_ptr");
        bad = (op > 1) || (a_ptr[2:0] != 0) || (res_ptr[2:0] != 0) || (op == 0 && b_ptr[2:0] != 0);
        sum = '0;
        if (!bad) begin
            for (int i = 0; i < len; i++) begin
                exp_rd_q.push_back(PW'(a_ptr + 64'(i) * 8));
                if (op == 0) begin
                    exp_rd_q.push_back(PW'(b_ptr + 64'(i) * 8));
                    sum = sum + av[i] * bv[i];
                end else begin
                    sum = sum + av[i];
                end
            end
            exp_st_addr_q.push_back(PW'(res_ptr));
            exp_st_data_q.push_back(sum);
        end
        base = st_acks;
        csr(1, 8'h28, 64'd1, '0, "wr_start");
    endtask

    task automatic finish_op(input bit bad, input logic [DW-1:0] sum, input int base);
        int n = 0;
        if (bad) begin
            repeat (5) @(negedge clk);
            model_status = 3'b110;
        end else begin
            while (st_acks == base && n < 3000) begin
                @(negedge clk);
                n++;
            end
            if (st_acks == base) fail_now("op_completion_timeout");
            repeat (3) @(negedge clk);
            model_status = 3'b010;
            model_result = sum;
        end
        csr(0, 8'h30, '0, 64'(model_status), "status_after_op");
        csr(0, 8'h38, '0, model_result, "result_after_op");
        drain();
        chk("reads_all_issued", 64'(exp_rd_q.size()), 64'd0);
        chk("store_issued", 64'(exp_st_addr_q.size()), 64'd0);
    endtask

    task automatic run_op(input logic [DW-1:0] a_ptr, input logic [DW-1:0] b_ptr, input int len,
                          input logic [DW-1:0] op, input logic [DW-1:0] res_ptr);
        bit bad;
        logic [DW-1:0] sum;
        int base;
        setup_and_start(a_ptr, b_ptr, len, op, res_ptr, bad, sum, base);
        finish_op(bad, sum, base);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit            bad;
        logic [DW-1:0] sum;
        int            base, n;
        csr_v_i = 1'b0; csr_w_i = 1'b0; csr_addr_i = '0; csr_data_i = '0;
        model_status = '0; model_result = '0;
        reset_i = 1'b1;
        repeat (3) @(negedge clk);
        reset_i = 1'b0;

        chk("rst_csr_ready", {63'd0, csr_ready_o}, 64'd1);
        chk("rst_csr_resp_v", {63'd0, csr_resp_v_o}, 64'd0);
        chk("rst_mem_req_v", {63'd0, mem_req_v_o}, 64'd0);
        csr(0, 8'h30, '0, '0, "rst_status");
        csr(0, 8'h38, '0, '0, "rst_result");
        csr(0, 8'h00, '0, '0, "rst_a_ptr");

        // Dot product {1,2,3}.{4,5,6} = 32
        av[0] = 1; av[1] = 2; av[2] = 3; bv[0] = 4; bv[1] = 5; bv[2] = 6;
        run_op(64'h1000, 64'h2000, 3, 0, 64'h3000);
        csr(0, 8'h00, '0, 64'h1000, "rd_a_ptr");
        csr(0, 8'h10, '0, 64'd3, "rd_len");
        csr(0, 8'h28, '0, '0, "rd_start_zero");
        csr(0, 8'h40, '0, '0, "rd_unmapped");
        csr(1, 8'h48, 64'hFFFF, '0, "wr_unmapped");

        // Reduction of {10,20,30,40}; any B fetch would be an unexpected read
        av[0] = 10; av[1] = 20; av[2] = 30; av[3] = 40;
        run_op(64'h4000, 64'h5000, 4, 1, 64'h3008);

        // len = 0 stores zero
        run_op(64'h1000, 64'h2000, 0, 0, 64'h3010);

        // Misaligned A pointer and illegal op: error with no traffic
        run_op(64'h1004, 64'h2000, 3, 0, 64'h3000);
        csr(1, 8'h30, '0, '0, "wr_status_clear");
        model_status = 3'b000;
        csr(0, 8'h30, '0, '0, "status_cleared");
        run_op(64'h1000, 64'h2000, 3, 5, 64'h3000);

        // Backpressure on both the memory request and the CSR response
        stall_n = 5; yumi_fixed = 3;
        for (int i = 0; i < 3; i++) begin
            av[i] = {$urandom, $urandom};
            bv[i] = {$urandom, $urandom};
        end
        run_op(64'h7000, 64'h7800, 3, 0, 64'h3018);
        stall_n = 0; yumi_fixed = -1;

        // Writes and a second start while busy are ignored
        dly_lo = 4; dly_hi = 6;
        av[0] = 7; av[1] = 8; av[2] = 9; bv[0] = 3; bv[1] = 2; bv[2] = 1;
        setup_and_start(64'h6000, 64'h6800, 3, 0, 64'h3020, bad, sum, base);
        csr(1, 8'h00, 64'h9000, '0, "wr_a_ptr_busy");
        csr(1, 8'h28, 64'd1, '0, "wr_start_busy");
        csr(1, 8'h10, 64'd1, '0, "wr_len_busy");
        finish_op(bad, sum, base);
        csr(0, 8'h00, '0, 64'h6000, "a_ptr_kept");
        csr(0, 8'h10, '0, 64'd3, "len_kept");
        dly_lo = 0; dly_hi = 2;

        // Product and accumulate wrap: 2 * (2^63 * 2^63) mod 2^64 = 0
        av[0] = 64'h8000_0000_0000_0000; av[1] = 64'h8000_0000_0000_0000;
        bv[0] = 64'h8000_0000_0000_0000; bv[1] = 64'h8000_0000_0000_0000;
        run_op(64'h8000, 64'h8800, 2, 0, 64'h3028);

        // Reset while waiting for B[0]; its response arrives after reset
        dly_lo = 8; dly_hi = 8;
        av[0] = 5; av[1] = 6; bv[0] = 7; bv[1] = 8;
        setup_and_start(64'hA000, 64'hA800, 2, 0, 64'h3030, bad, sum, base);
        base = rd_hs;
        drain();
        n = 0;
        while (rd_hs < base + 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (rd_hs < base + 2) fail_now("b_fetch_timeout");
        @(negedge clk);
        reset_i = 1'b1;
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        exp_rd_q.delete();
        exp_st_addr_q.delete();
        exp_st_data_q.delete();
        chk("post_rst_mem_req_v", {63'd0, mem_req_v_o}, 64'd0);
        chk("post_rst_csr_resp_v", {63'd0, csr_resp_v_o}, 64'd0);
        dly_lo = 0; dly_hi = 2;
        repeat (15) @(negedge clk);
        model_status = '0; model_result = '0;
        csr(0, 8'h30, '0, '0, "post_rst_status");
        csr(0, 8'h00, '0, '0, "post_rst_a_ptr");
        csr(0, 8'h38, '0, '0, "post_rst_result");
        drain();

        // Randomised operations
        for (int t = 0; t < 6; t++) begin
            int len;
            logic [DW-1:0] op;
            len = int'($urandom_range(1, 5));
            op  = 64'($urandom_range(0, 1));
            for (int i = 0; i < 8; i++) begin
                av[i] = {$urandom, $urandom};
                bv[i] = {$urandom, $urandom};
            end
            run_op(64'h10000 + 64'(t) * 64'h1000, 64'h10800 + 64'(t) * 64'h1000,
                   len, op, 64'h80000 + 64'(t) * 8);
        end

        drain();
        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
